// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered output stage behind the ALU result/flag muxes. It captures the
// selected result, its operation code and the carry/overflow flags, and
// derives N/Z. Results are held in a 2-entry FIFO with valid/ready on both
// sides. Operation codes above 9 are consumed without storing anything and
// raise a sticky IllegalOp flag.

module alu_result_stage #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         InValid,
  output logic         InReady,
  input  logic [n-1:0] Result,
  input  logic [3:0]   ALUControl,
  input  logic         CarryIn,
  input  logic         OverflowIn,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [n-1:0] OutResult,
  output logic [3:0]   OutOp,
  output logic [3:0]   OutFlags,
  output logic         IllegalOp
);

  // One stored result: the data word, the op that produced it and {N,Z,C,V}
  typedef struct packed {
    logic [n-1:0] result;
    logic [3:0]   op;
    logic [3:0]   flags;
  } entry_t;

  // Occupancy of the two-entry queue
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  entry_t r_head;
  entry_t r_tail;
  logic   r_inReady;
  logic   r_outValid;
  logic   r_illegalOp;

  logic   w_push;
  logic   w_pop;
  logic   w_legalOp;
  logic   w_legalPush;
  logic   w_illegalPush;
  entry_t w_newEntry;

  // Handshake decode and construction of the entry that a push would store
  always_comb begin
    w_push               = InValid && r_inReady;
    w_pop                = r_outValid && OutReady;
    w_legalOp            = (ALUControl <= 4'd9);
    w_legalPush          = w_push && w_legalOp;
    w_illegalPush        = w_push && !w_legalOp;
    w_newEntry.result    = Result;
    w_newEntry.op        = ALUControl;
    w_newEntry.flags     = {Result[n-1], (Result == '0), CarryIn, OverflowIn};
  end

  // Occupancy FSM with storage and registered handshake outputs; the head
  // register is the visible output and simply keeps its value after the
  // last pop, so the outputs hold the last popped entry while empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_head      <= '0;
      r_tail      <= '0;
      r_inReady   <= 1'b0;
      r_outValid  <= 1'b0;
      r_illegalOp <= 1'b0;
    end else begin
      r_inReady <= 1'b1;
      if (w_illegalPush) begin
        r_illegalOp <= 1'b1;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_legalPush) begin
            r_head     <= w_newEntry;
            r_state    <= S_ONE;
            r_outValid <= 1'b1;
          end else begin
            r_outValid <= 1'b0;
          end
        end
        S_ONE: begin
          if (w_pop && w_legalPush) begin
            r_head     <= w_newEntry;
            r_outValid <= 1'b1;
          end else if (w_pop) begin
            r_state    <= S_EMPTY;
            r_outValid <= 1'b0;
          end else if (w_legalPush) begin
            r_tail     <= w_newEntry;
            r_state    <= S_FULL;
            r_outValid <= 1'b1;
            r_inReady  <= 1'b0;
          end else begin
            r_outValid <= 1'b1;
          end
        end
        S_FULL: begin
          r_outValid <= 1'b1;
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= S_ONE;
          end else begin
            r_inReady <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign InReady   = r_inReady;
  assign OutValid  = r_outValid;
  assign OutResult = r_head.result;
  assign OutOp     = r_head.op;
  assign OutFlags  = r_head.flags;
  assign IllegalOp = r_illegalOp;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage placed directly downstream of the ALU's 10-to-1 result/flag multiplexers. It captures the selected result, the operation code that selected it, and the carry/overflow flags, and derives the negative/zero flags. It holds the results in a 2-entry FIFO with valid/ready handshakes on both sides, so a stalled consumer (register file write-back or display logic) never loses a result. Illegal operation codes (ALUControl > 9, for which the mux defines no result) are dropped and reported through a sticky error flag.

## Interface
- n, default 4, data width of Result and OutResult (n >= 2)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- InValid  in  1  upstream result valid
- InReady  out  1  stage can accept (entry free)
- Result  in  n  selected ALU result from the result mux
- ALUControl  in  4  operation code that drove the muxes
- CarryIn  in  1  carry flag from the flag mux
- OverflowIn  in  1  overflow flag from the flag mux
- OutValid  out  1  head entry valid
- OutReady  in  1  downstream accepts head
- OutResult  out  n  head result
- OutOp  out  4  head operation code
- OutFlags  out  4  head flags {N, Z, C, V}
- IllegalOp  out  1  sticky: a transfer with ALUControl > 9 was dropped

## Operation
- One clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising clk edge.
- Push: InValid && InReady at an edge. Pop: OutValid && OutReady at an edge.
- A push with ALUControl <= 9 writes one entry. The entry holds:
  - Result
  - ALUControl
  - N = Result[n-1]
  - Z = (Result == 0)
  - C = CarryIn
  - V = OverflowIn
- A push with ALUControl in 10..15 is consumed (handshake completes) but writes no entry. IllegalOp goes to 1 at that edge and stays 1 until reset.
- Occupancy state machine:
  - EMPTY (0 entries) -> ONE on a legal push.
  - ONE -> EMPTY on a pop with no legal push.
  - ONE -> FULL on a legal push with no pop.
  - ONE -> ONE on a pop plus a legal push at the same edge; the new entry becomes head.
  - FULL -> ONE on a pop.
- InReady = 1 in EMPTY and ONE, and 0 in FULL. There is no same-cycle pass-through when full: a push is refused in FULL even if a pop happens at that edge.
- OutValid = 1 in ONE and FULL.
- Order is strict FIFO. In FULL the head is always the older entry.
- OutResult, OutOp and OutFlags show the head entry. When OutValid = 0 they hold the last popped values; they are 0 after reset.
- A push or pop while rst_n = 0 is ignored.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Reset values:
  - InReady = 0 while rst_n = 0, and 1 from the first cycle after release.
  - OutValid = 0, OutResult = 0, OutOp = 0, OutFlags = 0, IllegalOp = 0.
  - State = EMPTY.
- Latency: a legal push at edge k makes OutValid = 1 with that data in cycle k+1.
- Throughput: one transfer per cycle with OutReady held at 1, with occupancy staying at ONE.
- Reset asserted mid-operation discards all stored entries and clears IllegalOp at that edge.
- Data under stall: while OutValid = 1 and OutReady = 0, the head data must not change.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with InValid = 1 -> InReady = 0, OutValid = 0, all data outputs 0; the cycle after release InReady = 1 and nothing has been stored.
- Single transfer, n=4: push Result=4'h0, ALUControl=4'h3, CarryIn=1, OverflowIn=0 -> next cycle OutValid = 1, OutResult = 0, OutOp = 3, OutFlags = 4'b0110; pop -> OutValid = 0.
- Backpressure: OutReady = 0; push 4'h9 (op 1), then 4'h2 (op 2) -> FULL, InReady = 0, a third push of 4'h5 is refused, head stays 9 (N=1, flags 4'b10xx); raise OutReady -> outputs appear in the order 9, 2.
- Streaming: OutReady = 1, push 1, 2, 3, 4 on consecutive edges -> OutResult = 1, 2, 3, 4 in consecutive cycles, occupancy stays ONE, InReady stays 1.
- Illegal op: push ALUControl = 4'hA with Result = 4'h7 -> handshake completes, OutValid stays 0, IllegalOp = 1; a following legal push still flows; IllegalOp stays 1 until rst_n = 0.
- Mid-stream reset: in FULL, drive rst_n = 0 for one edge -> OutValid = 0, IllegalOp = 0, state EMPTY, and the old entries never reappear.
